// File: rtl/led_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : led_seq_ctrl_if
// Description : Switch/button/LED bundle for the LED chase sequencer.
//               master : drives sw, btn_run, clr, bounce; observes outputs
//               slave  : the sequencer (consumes inputs, drives tick, state,
//                        count, led)
//   sw[1:0]    speed select (00 slow, 10 fast, 01/11 very fast)
//   btn_run    raw run/pause button, asynchronous to clk
//   clr        synchronous clear
//   bounce     0 = wrap counting, 1 = ping-pong counting
//   tick       one-cycle prescaler pulse
//   state[1:0] 00 IDLE, 01 RUN, 10 PAUSE
//   count[2:0] pattern index
//   led[3:0]   {led4,led3,led2,led1}
// Revision    : 1.0 - initial release
// ============================================================================
interface led_seq_ctrl_if;
    logic [1:0] sw;
    logic       btn_run;
    logic       clr;
    logic       bounce;
    logic       tick;
    logic [1:0] state;
    logic [2:0] count;
    logic [3:0] led;

    modport master (
        output sw, btn_run, clr, bounce,
        input  tick, state, count, led
    );

    modport slave (
        input  sw, btn_run, clr, bounce,
        output tick, state, count, led
    );
endinterface
`default_nettype wire

// File: rtl/led_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : led_seq_ctrl
// Description : Run/pause sequencer for the 4-LED chase bar. A free-running
//               prescaler produces a tick enable at a rate chosen by sw; the
//               FSM (IDLE/RUN/PAUSE) is toggled by a synchronised button press
//               and steps a 3-bit pattern counter in wrap or ping-pong mode.
//               The LED pattern is decoded combinationally from the count.
// Ports       : clk  - system clock
//               rst  - asynchronous active-low reset
//               bus  - led_seq_ctrl_if.slave (sw, btn_run, clr, bounce in;
//                      tick, state, count, led out)
// Revision    : 1.0 - initial release
// ============================================================================
module led_seq_ctrl #(
    parameter int DIV_SLOW  = 26,
    parameter int DIV_FAST  = 25,
    parameter int DIV_VFAST = 24
) (
    input  wire logic           clk,
    input  wire logic           rst,
    led_seq_ctrl_if.slave       bus
);

    localparam logic [1:0] c_st_idle  = 2'b00;
    localparam logic [1:0] c_st_run   = 2'b01;
    localparam logic [1:0] c_st_pause = 2'b10;

    localparam logic [DIV_SLOW-1:0] c_presc_one = {{(DIV_SLOW-1){1'b0}}, 1'b1};

    logic [DIV_SLOW-1:0] r_presc;
    logic                r_s1;
    logic                r_s2;
    logic                r_s3;
    logic [1:0]          r_state;
    logic [2:0]          r_count;
    logic                r_dir_down;

    logic                w_tick;
    logic                w_press;
    logic [2:0]          w_count_nxt;
    logic                w_dir_down_nxt;
    logic [3:0]          w_led;

    // Prescaler is never cleared by clr or by sw changes, so a speed change
    // simply waits for the low bits of the new width to fill up.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + c_presc_one;
        end
    end

    always_comb begin
        w_tick = 1'b0;
        case (bus.sw)
            2'b00:   w_tick = &r_presc[DIV_SLOW-1:0];
            2'b10:   w_tick = &r_presc[DIV_FAST-1:0];
            default: w_tick = &r_presc[DIV_VFAST-1:0];
        endcase
    end

    // Two-flop synchroniser followed by an edge-detect flop; a held button
    // gives a single press because s3 catches up with s2 one cycle later.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= bus.btn_run;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign w_press = r_s2 & ~r_s3;

    // Next count for a RUN-state tick. Wrap mode always leaves dir up, so a
    // later switch to ping-pong resumes counting upwards.
    always_comb begin
        w_count_nxt    = r_count;
        w_dir_down_nxt = r_dir_down;
        if (!bus.bounce) begin
            w_count_nxt    = r_count + 3'd1;
            w_dir_down_nxt = 1'b0;
        end else if (!r_dir_down) begin
            if (r_count == 3'd7) begin
                w_count_nxt    = 3'd6;
                w_dir_down_nxt = 1'b1;
            end else begin
                w_count_nxt = r_count + 3'd1;
            end
        end else begin
            if (r_count == 3'd0) begin
                w_count_nxt    = 3'd1;
                w_dir_down_nxt = 1'b0;
            end else begin
                w_count_nxt = r_count - 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= c_st_idle;
            r_count    <= 3'd0;
            r_dir_down <= 1'b0;
        end else if (bus.clr) begin
            r_state    <= c_st_idle;
            r_count    <= 3'd0;
            r_dir_down <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_press) begin
                        r_state <= c_st_run;
                    end
                end
                c_st_run: begin
                    // A tick coinciding with the pausing press still counts.
                    if (w_tick) begin
                        r_count    <= w_count_nxt;
                        r_dir_down <= w_dir_down_nxt;
                    end
                    if (w_press) begin
                        r_state <= c_st_pause;
                    end
                end
                c_st_pause: begin
                    if (w_press) begin
                        r_state <= c_st_run;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    always_comb begin
        w_led = 4'b0000;
        case (r_count)
            3'd0: w_led = 4'b0000;
            3'd1: w_led = 4'b0001;
            3'd2: w_led = 4'b0011;
            3'd3: w_led = 4'b0111;
            3'd4: w_led = 4'b1111;
            3'd5: w_led = 4'b1110;
            3'd6: w_led = 4'b1100;
            3'd7: w_led = 4'b1000;
            default: w_led = 4'b0000;
        endcase
    end

    assign bus.tick  = w_tick;
    assign bus.state = r_state;
    assign bus.count = r_count;
    assign bus.led   = w_led;

endmodule
`default_nettype wire

// File: tb/tb_led_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_seq_ctrl
// Description : Self-checking bench for led_seq_ctrl. A behavioural model
//               (cycle number, button sample history, ping-pong position)
//               predicts tick/state/count/led after every clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_seq_ctrl;

    localparam int P_SLOW  = 4;
    localparam int P_FAST  = 3;
    localparam int P_VFAST = 2;

    logic clk;
    logic rst;

    led_seq_ctrl_if ifc ();

    led_seq_ctrl #(
        .DIV_SLOW  (P_SLOW),
        .DIV_FAST  (P_FAST),
        .DIV_VFAST (P_VFAST)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: cycles since reset release, button samples (oldest first),
    // FSM state 0/1/2, and position 0..13 around the ping-pong loop.
    int m_cyc;
    bit hb[$];
    int m_state;
    int m_pos;

    logic [3:0] led_tab [8] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111,
                                4'b1111, 4'b1110, 4'b1100, 4'b1000};

    function automatic int cnt_of(input int pos);
        return (pos <= 7) ? pos : 14 - pos;
    endfunction

    function automatic int n_of(input logic [1:0] s);
        if (s == 2'b00) return P_SLOW;
        if (s == 2'b10) return P_FAST;
        return P_VFAST;
    endfunction

    function automatic bit tick_of(input int cyc, input logic [1:0] s);
        return (((cyc % (1 << P_SLOW)) + 1) % (1 << n_of(s))) == 0;
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        n_checks++;
        n_fail++;
        $error("FAIL %s observed=timeout expected=event", tag);
    endtask

    task automatic model_reset();
        m_cyc   = 0;
        hb      = '{0, 0, 0};
        m_state = 0;
        m_pos   = 0;
    endtask

    task automatic check_all();
        check("state", {6'd0, ifc.state}, m_state[7:0]);
        check("count", {5'd0, ifc.count}, cnt_of(m_pos));
        check("led",   {4'd0, ifc.led},   {4'd0, led_tab[cnt_of(m_pos)]});
        check("tick",  {7'd0, ifc.tick},  {7'd0, tick_of(m_cyc, ifc.sw)});
    endtask

    // One clock: predict from pre-edge inputs, advance model, check at edge+1.
    task automatic step();
        bit         t, p, c, b, btn;
        int         old_cnt;
        t   = tick_of(m_cyc, ifc.sw);
        p   = hb[hb.size()-2] && !hb[hb.size()-3];
        c   = ifc.clr;
        b   = ifc.bounce;
        btn = ifc.btn_run;
        old_cnt = cnt_of(m_pos);
        @(posedge clk);
        if (c) begin
            m_state = 0;
            m_pos   = 0;
        end else begin
            case (m_state)
                0: if (p) m_state = 1;
                1: begin
                    if (t) m_pos = b ? (m_pos + 1) % 14 : (cnt_of(m_pos) + 1) % 8;
                    if (p) m_state = 2;
                end
                default: if (p) m_state = 1;
            endcase
        end
        hb.push_back(btn);
        if (hb.size() > 6) void'(hb.pop_front());
        m_cyc++;
        #1;
        check_all();
        if (old_cnt == 7 && cnt_of(m_pos) == 6)
            check("turn_led", {4'd0, ifc.led}, 8'b1100);
    endtask

    task automatic release_btn();
        ifc.btn_run = 1'b0;
        repeat (3) step();
    endtask

    // Raise the button so its press lands in the same cycle as a tick.
    task automatic press_at_tick(input string tag);
        int g;
        g = 0;
        while ((((m_cyc % (1 << P_SLOW)) + 3) % (1 << n_of(ifc.sw))) != 0 && g < 64) begin
            step();
            g++;
        end
        if (g >= 64) timeout(tag);
        ifc.btn_run = 1'b1;
        step();
        step();
        check(tag, {7'd0, ifc.tick}, 8'd1);
    endtask

    initial begin
        int nt, c0, g, hold;
        ifc.sw      = 2'b00;
        ifc.btn_run = 1'b0;
        ifc.clr     = 1'b0;
        ifc.bounce  = 1'b0;
        rst         = 1'b0;
        #1;
        check("rst_state", {6'd0, ifc.state}, 8'd0);
        check("rst_count", {5'd0, ifc.count}, 8'd0);
        check("rst_led",   {4'd0, ifc.led},   8'd0);
        check("rst_tick",  {7'd0, ifc.tick},  8'd0);
        #11 rst = 1'b1;
        model_reset();

        // Idle, slow rate: four ticks in 64 cycles, nothing else moves.
        nt = 0;
        repeat (64) begin
            step();
            if (ifc.tick === 1'b1) nt++;
        end
        check("idle_ticks", nt[7:0], 8'd4);

        // Start with a 10-cycle press at the very fast rate.
        ifc.sw      = 2'b01;
        ifc.bounce  = 1'b0;
        ifc.btn_run = 1'b1;
        step();
        check("start_e0", {6'd0, ifc.state}, 8'd0);
        step();
        check("start_e1", {6'd0, ifc.state}, 8'd0);
        step();
        check("start_e2", {6'd0, ifc.state}, 8'd1);
        repeat (7) step();
        check("held_once", {6'd0, ifc.state}, 8'd1);
        ifc.btn_run = 1'b0;
        repeat (40) step();

        // Ping-pong for a full loop and then some.
        ifc.bounce = 1'b1;
        repeat (70) step();
        ifc.bounce = 1'b0;

        // Pausing press on a tick: the tick still advances the count.
        press_at_tick("pause_tick");
        c0 = cnt_of(m_pos);
        step();
        check("pause_state", {6'd0, ifc.state}, 8'd2);
        check("pause_count", {5'd0, ifc.count}, (c0 + 1) % 8);
        release_btn();

        // Resuming press on a tick: that tick is dropped.
        press_at_tick("resume_tick");
        c0 = cnt_of(m_pos);
        step();
        check("resume_state", {6'd0, ifc.state}, 8'd1);
        check("resume_count", {5'd0, ifc.count}, c0[7:0]);
        release_btn();

        // clr beats both press and tick at count 5.
        g = 0;
        while (!(m_state == 1 && cnt_of(m_pos) == 5 && (m_cyc % 4) == 0) && g < 200) begin
            step();
            g++;
        end
        if (g >= 200) timeout("reach_count5");
        press_at_tick("clr_tick");
        check("clr_pre_count", {5'd0, ifc.count}, 8'd5);
        ifc.clr = 1'b1;
        step();
        ifc.clr = 1'b0;
        check("clr_state", {6'd0, ifc.state}, 8'd0);
        check("clr_count", {5'd0, ifc.count}, 8'd0);
        check("clr_led",   {4'd0, ifc.led},   8'd0);
        release_btn();

        // Back to RUN, then change speed at prescaler = 5.
        ifc.btn_run = 1'b1;
        repeat (3) step();
        release_btn();
        ifc.sw = 2'b00;
        g = 0;
        while ((m_cyc % 16) != 5 && g < 40) begin
            step();
            g++;
        end
        if (g >= 40) timeout("reach_presc5");
        ifc.sw = 2'b10;
        #1;
        check("sw_chg_now", {7'd0, ifc.tick}, 8'd0);
        step();
        check("sw_chg_p6", {7'd0, ifc.tick}, 8'd0);
        step();
        check("sw_chg_p7", {7'd0, ifc.tick}, 8'd1);

        // Asynchronous reset mid-cycle.
        #2 rst = 1'b0;
        #1;
        check("arst_state", {6'd0, ifc.state}, 8'd0);
        check("arst_count", {5'd0, ifc.count}, 8'd0);
        check("arst_led",   {4'd0, ifc.led},   8'd0);
        check("arst_tick",  {7'd0, ifc.tick},  8'd0);
        @(posedge clk);
        #3 rst = 1'b1;
        model_reset();

        // Randomised traffic.
        hold = 0;
        repeat (1500) begin
            if ($urandom_range(0, 19) == 0) ifc.sw = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 29) == 0) ifc.bounce = ~ifc.bounce;
            if (hold == 0) begin
                ifc.btn_run = 1'($urandom_range(0, 1));
                hold = $urandom_range(1, 12);
            end
            hold--;
            ifc.clr = ($urandom_range(0, 59) == 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
